memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 16, max ACCESS cycles awaiting dmem_ack before abort (range 2..255).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 clear  in  1  asynchronous, active-low reset; all state resets immediately on clear=0.
REQ-004 turn_off  in  1  global pipeline freeze; 1 = EX/MEM register holds.
REQ-005 alu_res  in  32  EX result; memory byte address for loads/stores.
REQ-006 store_data  in  32  store operand from EX.
REQ-007 rd_buf3  in  4  destination register from EX.
REQ-008 cu_flags3  in  8  control flags from EX; bit7 mem_w, bit6 mem_r, bit5 reg_w, bit4 wb_sel (1 = memory data).
REQ-009 dmem_rdata  in  32  read data from data memory, valid with dmem_ack.
REQ-010 dmem_ack  in  1  data memory completion strobe.
REQ-011 dmem_req  out  1  access request, held high until ack or abort.
REQ-012 dmem_we  out  1  1 = write access.
REQ-013 dmem_addr  out  32  = latched alu_res.
REQ-014 dmem_wdata  out  32  = latched store_data.
REQ-015 mem_out  out  32  result to write-back stage.
REQ-016 rd_buf4  out  4  destination register to write-back stage.
REQ-017 cu_flags4  out  8  flags to write-back stage.
REQ-018 stall_out  out  1  1 = upstream stages must hold.
REQ-019 mem_err  out  1  sticky timeout error flag.

Function
REQ-020 EX/MEM register SHALL capture alu_res, store_data, rd_buf3, cu_flags3 on rising clk when turn_off=0 and stall_out=0; otherwise hold.
REQ-021 FSM states SHALL be IDLE, ACCESS, DONE; reset state IDLE.
REQ-022 On a capture edge, next state SHALL be ACCESS if captured mem_r|mem_w, else IDLE; in DONE with no capture, state SHALL stay DONE.
REQ-023 In ACCESS: dmem_req=1, dmem_we=mem_w, stall_out=1, cu_flags4 = latched flags with bit5 forced 0 (bubble to write-back).
REQ-024 In ACCESS, dmem_ack=1 at an edge SHALL latch dmem_rdata into load buffer and move to DONE; dmem_req SHALL drop in DONE.
REQ-025 Cycle counter SHALL clear on ACCESS entry and increment per ACCESS cycle; on reaching ACK_TIMEOUT without ack, FSM SHALL go DONE, load buffer = 0, mem_err set (sticky), and that instruction's reg_w suppressed.
REQ-026 Minimum load latency: request cycle + ack cycle; ack in first ACCESS cycle gives DONE next cycle.
REQ-027 In IDLE/DONE: stall_out=0, dmem_req=0, cu_flags4 = latched flags (except REQ-025 suppression), rd_buf4 = latched rd.
REQ-028 mem_out SHALL be load buffer when wb_sel=1 and mem_r=1, else latched alu_res.
REQ-029 mem_r and mem_w both set SHALL be treated as a write; read data discarded.
REQ-030 dmem_ack while not in ACCESS SHALL be ignored.
REQ-031 turn_off=1 during ACCESS SHALL NOT abort the handshake; completion still proceeds to DONE and then holds.
REQ-032 Address bits [1:0] SHALL pass through unmodified; alignment is not checked.

Reset
REQ-033 clear=0 SHALL immediately force state IDLE, counter 0, all latched registers and load buffer 0, mem_err 0, dmem_req 0, stall_out 0, all outputs 0.
REQ-034 clear asserted mid-ACCESS SHALL drop dmem_req asynchronously; the access is lost.

Verification
REQ-035 ALU op: alu_res=0x0000_0010, rd=3, flags=0x20 -> next cycle mem_out=0x10, rd_buf4=3, cu_flags4=0x20, stall_out=0, dmem_req=0.
REQ-036 Load: flags=0x70, addr 0x100, ack after 3 ACCESS cycles with rdata=0xDEAD_BEEF -> stall_out=1 and cu_flags4[5]=0 for 3 cycles, then mem_out=0xDEADBEEF, cu_flags4=0x70.
REQ-037 Store: flags=0x80, addr 0x200, data 0x1234 -> dmem_req=1, dmem_we=1, dmem_wdata=0x1234 until ack; no reg_w at output.
REQ-038 Timeout: load with no ack -> after 16 ACCESS cycles DONE, mem_err=1, mem_out=0, cu_flags4[5]=0; mem_err stays 1 until clear.
REQ-039 Freeze/reset: turn_off=1 during ACCESS, ack arrives -> DONE reached, inputs not captured until turn_off=0; clear=0 mid-ACCESS -> dmem_req=0 and all outputs 0 without a clock edge.

Source files
------------

// File: rtl/memory_access.sv
// memory_access: EX/MEM pipeline register with a data-memory handshake FSM and ack timeout
module memory_access #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        turn_off,
  input  logic [31:0] alu_res,
  input  logic [31:0] store_data,
  input  logic [3:0]  rd_buf3,
  input  logic [7:0]  cu_flags3,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [31:0] mem_out,
  output logic [3:0]  rd_buf4,
  output logic [7:0]  cu_flags4,
  output logic        stall_out,
  output logic        mem_err
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [7:0] LAST = 8'(ACK_TIMEOUT - 1);
  state_t      state;
  logic [31:0] addr_q, data_q, load_buf;
  logic [3:0]  rd_q;
  logic [7:0]  flags_q, cnt;
  logic        kill, capture;
  assign stall_out  = state == ACCESS;
  assign capture    = !turn_off && !stall_out;
  assign dmem_req   = stall_out;
  assign dmem_we    = stall_out && flags_q[7];
  assign dmem_addr  = addr_q;
  assign dmem_wdata = data_q;
  assign rd_buf4    = rd_q;
  // reg_w is bubbled while the access is in flight and for a timed-out instruction
  assign cu_flags4  = (stall_out || kill) ? {flags_q[7:6], 1'b0, flags_q[4:0]} : flags_q;
  // a write with mem_r also set is a write, so its read data never reaches write-back
  assign mem_out    = (flags_q[4] && flags_q[6] && !flags_q[7]) ? load_buf : addr_q;
  always_ff @(posedge clk or negedge clear)
    if (!clear) begin
      state    <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      rd_q     <= '0;
      flags_q  <= '0;
      load_buf <= '0;
      cnt      <= '0;
      kill     <= 1'b0;
      mem_err  <= 1'b0;
    end else if (capture) begin
      addr_q  <= alu_res;
      data_q  <= store_data;
      rd_q    <= rd_buf3;
      flags_q <= cu_flags3;
      cnt     <= '0;
      kill    <= 1'b0;
      state   <= (cu_flags3[7] || cu_flags3[6]) ? ACCESS : IDLE;
    end else if (state == ACCESS) begin
      if (dmem_ack) begin
        if (!flags_q[7]) load_buf <= dmem_rdata;
        state <= DONE;
      end else if (cnt == LAST) begin
        load_buf <= '0;
        mem_err  <= 1'b1;
        kill     <= 1'b1;
        state    <= DONE;
      end else cnt <= cnt + 8'd1;
    end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed and randomized checks of memory_access against a transaction-level model
module tb_memory_access;
  logic        clk = 1'b0, clear = 1'b0, turn_off = 1'b0, dmem_ack = 1'b0;
  logic [31:0] alu_res = '0, store_data = '0, dmem_rdata = '0;
  logic [3:0]  rd_buf3 = '0;
  logic [7:0]  cu_flags3 = '0;
  logic        dmem_req, dmem_we, stall_out, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, mem_out;
  logic [3:0]  rd_buf4;
  logic [7:0]  cu_flags4;
  int checks = 0, failures = 0;

  memory_access dut (
    .clk(clk), .clear(clear), .turn_off(turn_off), .alu_res(alu_res),
    .store_data(store_data), .rd_buf3(rd_buf3), .cu_flags3(cu_flags3),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .mem_out(mem_out), .rd_buf4(rd_buf4), .cu_flags4(cu_flags4),
    .stall_out(stall_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // reference: the instruction held in MEM, whether its access is outstanding,
  // how many cycles it has waited, and whether it was aborted
  logic [31:0] m_addr, m_data, m_buf;
  logic [3:0]  m_rd;
  logic [7:0]  m_fl;
  bit          m_busy, m_err, m_kill;
  int          m_waited;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_addr = '0; m_data = '0; m_buf = '0; m_rd = '0; m_fl = '0;
    m_busy = 0; m_err = 0; m_kill = 0; m_waited = 0;
  endtask

  task automatic m_edge();
    if (m_busy) begin
      if (dmem_ack) begin
        if (m_fl[6] && !m_fl[7]) m_buf = dmem_rdata;
        m_busy = 0;
      end else begin
        m_waited++;
        if (m_waited == 16) begin
          m_busy = 0; m_buf = 0; m_err = 1; m_kill = 1;
        end
      end
    end else if (!turn_off) begin
      m_addr = alu_res; m_data = store_data; m_rd = rd_buf3; m_fl = cu_flags3;
      m_kill = 0; m_waited = 0;
      m_busy = cu_flags3[7] || cu_flags3[6];
    end
  endtask

  task automatic compare_all();
    logic [7:0]  ef;
    logic [31:0] em;
    ef = m_fl;
    if (m_busy || m_kill) ef[5] = 1'b0;
    em = (m_fl[4] && m_fl[6] && !m_fl[7]) ? m_buf : m_addr;
    chk("stall", 32'(stall_out), 32'(m_busy));
    chk("req", 32'(dmem_req), 32'(m_busy));
    chk("we", 32'(dmem_we), 32'(m_busy && m_fl[7]));
    chk("addr", dmem_addr, m_addr);
    chk("wdata", dmem_wdata, m_data);
    chk("rd4", 32'(rd_buf4), 32'(m_rd));
    chk("flags4", 32'(cu_flags4), 32'(ef));
    chk("mem_out", mem_out, em);
    chk("mem_err", 32'(mem_err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    compare_all();
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] r, input logic [7:0] f);
    alu_res = a; store_data = d; rd_buf3 = r; cu_flags3 = f;
  endtask

  initial begin
    m_reset();
    #3;
    compare_all();
    chk("rst_out", mem_out, 32'h0);
    clear = 1'b1;
    step();

    issue(32'h10, 32'h0, 4'd3, 8'h20);
    step();
    chk("alu_mem_out", mem_out, 32'h10);
    chk("alu_rd4", 32'(rd_buf4), 32'd3);
    chk("alu_flags4", 32'(cu_flags4), 32'h20);
    chk("alu_stall", 32'(stall_out), 32'd0);
    chk("alu_req", 32'(dmem_req), 32'd0);

    issue(32'h100, 32'h0, 4'd5, 8'h70);
    step();
    issue(32'h55, 32'h66, 4'd7, 8'h20);
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall", 32'(stall_out), 32'd1);
      chk("ld_flag5", 32'(cu_flags4[5]), 32'd0);
      if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF; end
      turn_off = (i == 2);
      step();
    end
    dmem_ack = 1'b0;
    chk("ld_data", mem_out, 32'hDEADBEEF);
    chk("ld_flags4", 32'(cu_flags4), 32'h70);
    chk("ld_stall_end", 32'(stall_out), 32'd0);
    turn_off = 1'b0;

    issue(32'h200, 32'h1234, 4'd2, 8'h80);
    step();
    issue(32'h0, 32'h0, 4'd0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      chk("st_req", 32'(dmem_req), 32'd1);
      chk("st_we", 32'(dmem_we), 32'd1);
      chk("st_wdata", dmem_wdata, 32'h1234);
      chk("st_regw", 32'(cu_flags4[5]), 32'd0);
      dmem_ack = (i == 1);
      step();
    end
    dmem_ack = 1'b0;
    chk("st_req_end", 32'(dmem_req), 32'd0);

    issue(32'h300, 32'h0, 4'd9, 8'h70);
    step();
    issue(32'h44, 32'h0, 4'd1, 8'h20);
    for (int i = 0; i < 15; i++) step();
    chk("to_stall", 32'(stall_out), 32'd1);
    chk("to_err_pre", 32'(mem_err), 32'd0);
    step();
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_out", mem_out, 32'h0);
    chk("to_flag5", 32'(cu_flags4[5]), 32'd0);
    chk("to_stall_end", 32'(stall_out), 32'd0);
    step();
    chk("to_sticky", 32'(mem_err), 32'd1);
    chk("to_next", mem_out, 32'h44);

    issue(32'h400, 32'h0, 4'd4, 8'h70);
    step();
    turn_off = 1'b1;
    issue(32'h99, 32'h0, 4'd6, 8'h20);
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE0001;
    step();
    dmem_ack = 1'b0;
    chk("frz_done", 32'(stall_out), 32'd0);
    for (int i = 0; i < 2; i++) step();
    chk("frz_hold", mem_out, 32'hCAFE0001);
    chk("frz_rd", 32'(rd_buf4), 32'd4);
    turn_off = 1'b0;
    step();
    chk("frz_cap", mem_out, 32'h99);

    issue(32'h500, 32'h77, 4'd8, 8'h80);
    step();
    chk("clr_pre", 32'(dmem_req), 32'd1);
    clear = 1'b0;
    #1;
    m_reset();
    compare_all();
    chk("clr_req", 32'(dmem_req), 32'd0);
    chk("clr_err", 32'(mem_err), 32'd0);
    #1;
    clear = 1'b1;
    issue(32'h0, 32'h0, 4'd0, 8'h00);
    step();

    begin
      int quiet = 0;
      logic [7:0] pats [8] = '{8'h20, 8'h30, 8'h70, 8'h80, 8'hC0, 8'h00, 8'hF0, 8'h50};
      for (int n = 0; n < 3000; n++) begin
        if (quiet == 0 && $urandom_range(0, 99) == 0) quiet = 20;
        if (quiet > 0) quiet--;
        issue($urandom, $urandom, 4'($urandom),
              ($urandom_range(0, 3) == 0) ? 8'($urandom) : pats[$urandom_range(0, 7)]);
        turn_off = $urandom_range(0, 7) == 0;
        dmem_ack = quiet == 0 && $urandom_range(0, 2) == 0;
        dmem_rdata = $urandom;
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
